// File: rtl/spi_cmd_tx_pkg.sv
// Shared definitions for the SPI command transmitter: opcodes, FSM states, frame layout.
package spi_cmd_tx_pkg;

    localparam logic [3:0] SPI_OP_SET_CONFREG = 4'b0001;
    localparam logic [3:0] SPI_OP_SET_DIVISOR = 4'b0010;
    localparam int         FRAME_W            = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] data;
    } cmd_t;

    // Frame word: opcode, four zero bits, payload; sent bit 15 first.
    function automatic logic [FRAME_W-1:0] make_frame(input cmd_t c);
        return {c.op, 4'b0000, c.data};
    endfunction

endpackage

// File: rtl/spi_cmd_tx_fifo.sv
// Four-entry command FIFO (12-bit entries) used when SPI_CMD_FIFO_EN is defined.
module spi_cmd_fifo
    import spi_cmd_tx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t wdata,
    input  logic pop,
    output cmd_t rdata,
    output logic full,
    output logic empty
);

    cmd_t       mem [4];
    logic [1:0] wptr, rptr;
    logic [2:0] count;
    logic       do_push, do_pop;

    assign full    = (count == 3'd4);
    assign empty   = (count == 3'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    // Push and pop in one cycle leave the occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 2'd1;
            if (do_pop)  rptr <= rptr + 2'd1;
            count <= count + 3'(do_push) - 3'(do_pop);
        end
    end

endmodule

// File: rtl/spi_cmd_tx.sv
// SPI command transmitter: serialises {op, 4'b0, data} MSB-first on spck/mosi/ncs.
// Define SPI_CMD_FIFO_EN to buffer up to four commands ahead of the shifter.
module spi_cmd_tx
    import spi_cmd_tx_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int GAP_DIV = 2
) (
    input  logic       ck_1356meg,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       busy,
    output logic       spck,
    output logic       mosi,
    output logic       ncs
);

    localparam logic [7:0]  PH_RELOAD  = 8'(CLK_DIV - 1);
    localparam logic [11:0] GAP_RELOAD = 12'(GAP_DIV * CLK_DIV - 1);

    state_t               state, state_n;
    logic [7:0]           phase, phase_n;
    logic [3:0]           bit_idx, bit_n;
    logic                 sck_hi, hi_n;
    logic [FRAME_W-1:0]   shreg, sh_n;
    logic [11:0]          gap_cnt, gap_n;
    logic                 spck_n, mosi_n, ncs_n;
    logic                 take;
    cmd_t                 cmd_in, tx_cmd;

    assign cmd_in = '{op: cmd_op, data: cmd_data};
    assign busy   = (state != ST_IDLE);

`ifdef SPI_CMD_FIFO_EN
    logic fifo_full, fifo_empty;

    spi_cmd_fifo u_fifo (
        .clk   (ck_1356meg),
        .rst   (rst),
        .push  (cmd_valid),
        .wdata (cmd_in),
        .pop   (take),
        .rdata (tx_cmd),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign cmd_ready = !fifo_full;
    assign take      = (state == ST_IDLE) && !fifo_empty;
`else
    assign cmd_ready = (state == ST_IDLE);
    assign take      = cmd_valid && (state == ST_IDLE);
    assign tx_cmd    = cmd_in;
`endif

    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            state   <= ST_IDLE;
            phase   <= '0;
            bit_idx <= '0;
            sck_hi  <= 1'b0;
            shreg   <= '0;
            gap_cnt <= '0;
            spck    <= 1'b0;
            mosi    <= 1'b0;
            ncs     <= 1'b1;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            bit_idx <= bit_n;
            sck_hi  <= hi_n;
            shreg   <= sh_n;
            gap_cnt <= gap_n;
            spck    <= spck_n;
            mosi    <= mosi_n;
            ncs     <= ncs_n;
        end
    end

    // Outputs are computed one cycle ahead so spck/mosi/ncs come straight from flops.
    always_comb begin
        state_n = state;
        phase_n = phase;
        bit_n   = bit_idx;
        hi_n    = sck_hi;
        sh_n    = shreg;
        gap_n   = gap_cnt;
        spck_n  = spck;
        mosi_n  = mosi;
        ncs_n   = ncs;
        unique case (state)
            ST_IDLE: begin
                if (take) begin
                    state_n = ST_SHIFT;
                    sh_n    = make_frame(tx_cmd);
                    bit_n   = 4'd15;
                    phase_n = PH_RELOAD;
                    hi_n    = 1'b0;
                    spck_n  = 1'b0;
                    mosi_n  = sh_n[FRAME_W-1];
                    ncs_n   = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (phase != 8'd0) begin
                    phase_n = phase - 8'd1;
                end else begin
                    phase_n = PH_RELOAD;
                    if (!sck_hi) begin
                        hi_n   = 1'b1;
                        spck_n = 1'b1;
                    end else if (bit_idx == 4'd0) begin
                        state_n = ST_HOLD;
                        hi_n    = 1'b0;
                        spck_n  = 1'b0;
                    end else begin
                        // Next bit goes out together with the falling spck edge.
                        bit_n  = bit_idx - 4'd1;
                        hi_n   = 1'b0;
                        spck_n = 1'b0;
                        sh_n   = {shreg[FRAME_W-2:0], 1'b0};
                        mosi_n = shreg[FRAME_W-2];
                    end
                end
            end
            ST_HOLD: begin
                if (phase != 8'd0) begin
                    phase_n = phase - 8'd1;
                end else begin
                    state_n = ST_GAP;
                    gap_n   = GAP_RELOAD;
                    ncs_n   = 1'b1;
                    mosi_n  = 1'b0;
                end
            end
            ST_GAP: begin
                if (gap_cnt != 12'd0) gap_n = gap_cnt - 12'd1;
                else                  state_n = ST_IDLE;
            end
        endcase
    end

endmodule
